// File: rtl/cim_pkg.sv
// Shared definitions for the CIM result-drain block: FSM encoding, bank geometry,
// RAM word size and the count saturation helper.
package cim_pkg;

  localparam int          CIM_NUM_OUT_REGS = 16;
  localparam int          SEL_W            = 4;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_FLUSH = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } drain_state_e;

  function automatic logic [4:0] sat_count(input logic [4:0] c, input logic [4:0] lim);
    return (c > lim) ? lim : c;
  endfunction

endpackage

// File: rtl/cim_drain_pipe.sv
// CIM_LAT+1 deep valid/index/data pipeline turning select tags into RAM writes.
// Optional macro CIM_DRAIN_RELU_EN clamps negative captured words to zero.
module cim_drain_pipe
  import cim_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CIM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              issue_v,
  input  logic [SEL_W-1:0]  issue_idx,
  input  logic [31:0]       base,
  input  logic [DATA_W-1:0] cim_output,
  output logic              pending,
  output logic              ram_we,
  output logic [31:0]       ram_a,
  output logic [DATA_W-1:0] ram_d
);

  logic [CIM_LAT-1:0]            v_q, v_d;
  logic [CIM_LAT-1:0][SEL_W-1:0] idx_q, idx_d;
  logic                          we_q, we_d;
  logic [31:0]                   a_q, a_d;
  logic [DATA_W-1:0]             d_q, d_d;
  logic [DATA_W-1:0]             word;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      v_q   <= '0;
      idx_q <= '0;
      we_q  <= 1'b0;
      a_q   <= '0;
      d_q   <= '0;
    end else begin
      v_q   <= v_d;
      idx_q <= idx_d;
      we_q  <= we_d;
      a_q   <= a_d;
      d_q   <= d_d;
    end
  end

  always_comb begin
    v_d      = '0;
    idx_d    = '0;
    v_d[0]   = issue_v;
    idx_d[0] = issue_idx;
    for (int k = 1; k < CIM_LAT; k++) begin
      v_d[k]   = v_q[k-1];
      idx_d[k] = idx_q[k-1];
    end
  end

`ifdef CIM_DRAIN_RELU_EN
  always_comb word = cim_output[DATA_W-1] ? '0 : cim_output;
`else
  always_comb word = cim_output;
`endif

  // The last tag stage lines up with cim_output being valid for that index.
  always_comb begin
    we_d = v_q[CIM_LAT-1];
    a_d  = a_q;
    d_d  = d_q;
    if (we_d) begin
      a_d = base + ({{(32-SEL_W){1'b0}}, idx_q[CIM_LAT-1]} * WORD_BYTES);
      d_d = word;
    end
  end

  assign pending = |v_q;
  assign ram_we  = we_q;
  assign ram_a   = a_q;
  assign ram_d   = d_q;

endmodule

// File: rtl/cim_result_drain.sv
// Sweeps the CIM output-register bank into data RAM, optionally clearing the bank.
// Optional macro CIM_DRAIN_RELU_EN (in cim_drain_pipe) clamps negative words to zero.
module cim_result_drain
  import cim_pkg::*;
#(
  parameter int NUM_REGS = CIM_NUM_OUT_REGS,
  parameter int DATA_W   = 32,
  parameter int CIM_LAT  = 1
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [4:0]        count,
  input  logic              clear_after,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] cim_output,
  output logic [SEL_W-1:0]  cim_output_reg,
  output logic              cim_reset_output,
  output logic [31:0]       ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  output logic [3:0]        ram_be
);

  drain_state_e      state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [4:0]        n_q, n_d;
  logic [31:0]       base_q, base_d;
  logic              clr_q, clr_d;
  logic [4:0]        n_sat;
  logic              issue_v;
  logic              pending;

  assign n_sat = sat_count(count, 5'(NUM_REGS));

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      n_q     <= '0;
      base_q  <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      n_q     <= n_d;
      base_q  <= base_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    n_d     = n_q;
    base_d  = base_q;
    clr_d   = clr_q;
    unique case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (start) begin
          n_d     = n_sat;
          base_d  = {base_addr[31:2], 2'b00};
          clr_d   = clear_after;
          state_d = (n_sat == 5'd0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if ({1'b0, sel_q} == n_q - 5'd1) state_d = ST_FLUSH;
        else                             sel_d   = sel_q + 4'd1;
      end
      // Select stays at N-1 while the tag pipeline drains.
      ST_FLUSH: if (!pending) state_d = clr_q ? ST_CLEAR : ST_DONE;
      ST_CLEAR: state_d = ST_DONE;
      ST_DONE: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy             = (state_q != ST_IDLE);
    done             = (state_q == ST_DONE);
    cim_reset_output = (state_q == ST_CLEAR);
    issue_v          = (state_q == ST_ISSUE);
    cim_output_reg   = sel_q;
  end

  cim_drain_pipe #(
    .DATA_W (DATA_W),
    .CIM_LAT(CIM_LAT)
  ) u_pipe (
    .CLK       (CLK),
    .RES       (RES),
    .issue_v   (issue_v),
    .issue_idx (sel_q),
    .base      (base_q),
    .cim_output(cim_output),
    .pending   (pending),
    .ram_we    (ram_we),
    .ram_a     (ram_a),
    .ram_d     (ram_d)
  );

  assign ram_be = ram_we ? 4'hF : 4'h0;

endmodule

// File: tb/tb_cim_result_drain.sv
// Directed bench for cim_result_drain with a one-cycle-latency CIM register model.
module tb_cim_result_drain;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [4:0]  count = '0;
  logic        clear_after = 1'b0;
  logic        busy, done;
  logic [31:0] cim_output = '0;
  logic [3:0]  cim_output_reg;
  logic        cim_reset_output;
  logic [31:0] ram_a, ram_d;
  logic        ram_we;
  logic [3:0]  ram_be;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  bit cim_mode = 1'b0;

  int          wr_cnt, done_cnt, clr_cnt, overlap_cnt, be_err;
  int          done_cyc, clr_cyc, last_we_cyc;
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          wr_e[$];

  cim_result_drain dut (
    .CLK             (CLK),
    .RES             (RES),
    .start           (start),
    .base_addr       (base_addr),
    .count           (count),
    .clear_after     (clear_after),
    .busy            (busy),
    .done            (done),
    .cim_output      (cim_output),
    .cim_output_reg  (cim_output_reg),
    .cim_reset_output(cim_reset_output),
    .ram_a           (ram_a),
    .ram_d           (ram_d),
    .ram_we          (ram_we),
    .ram_be          (ram_be)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // CIM bank model: data for the selected register appears one cycle later.
  always @(posedge CLK) begin
    if (cim_mode) cim_output <= cim_output_reg[0] ? 32'h0000_0007 : 32'hFFFF_FFF0;
    else          cim_output <= 32'hA000_0000 + {28'd0, cim_output_reg};
  end

  always @(negedge CLK) begin
    if (ram_we) begin
      wr_cnt++;
      wr_a.push_back(ram_a);
      wr_d.push_back(ram_d);
      wr_e.push_back(cyc + 1);
      last_we_cyc = cyc;
      if (ram_be !== 4'hF) be_err++;
    end else if (ram_be !== 4'h0) be_err++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cim_reset_output) begin
      clr_cnt++;
      clr_cyc = cyc;
      if (ram_we) overlap_cnt++;
    end
  end

  task automatic clear_mon();
    wr_cnt = 0; done_cnt = 0; clr_cnt = 0; overlap_cnt = 0;
    done_cyc = -1; clr_cyc = -1; last_we_cyc = -1;
    wr_a.delete(); wr_d.delete(); wr_e.delete();
  endtask

  task automatic do_start(input logic [31:0] b, input logic [4:0] c, input logic clr);
    @(negedge CLK);
    start = 1'b1; base_addr = b; count = c; clear_after = clr;
    t0 = cyc + 1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy !== 1'b0 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout busy=%b exp=0", nm, busy);
    end
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s_done_timeout done=%b exp=1", nm, done);
    end
  endtask

  task automatic test_reset();
    RES = 1'b1;
    #3;
    total++; if (busy !== 1'b0)             begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)             begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (cim_output_reg !== 4'h0)   begin bad++; $display("FAIL rst_sel got=%h exp=0", cim_output_reg); end
    total++; if (cim_reset_output !== 1'b0) begin bad++; $display("FAIL rst_clr got=%b exp=0", cim_reset_output); end
    total++; if ({ram_we, ram_be, ram_a, ram_d} !== '0)
      begin bad++; $display("FAIL rst_ram got=%b/%h/%h/%h exp=0", ram_we, ram_be, ram_a, ram_d); end
    @(negedge CLK);
    RES = 1'b0;
    clear_mon();
  endtask

  task automatic test_full_drain();
    clear_mon();
    do_start(32'h100, 5'd16, 1'b0);
    total++; if (busy !== 1'b1 || cim_output_reg !== 4'h0)
      begin bad++; $display("FAIL full_first_sel busy=%b sel=%h exp=1/0", busy, cim_output_reg); end
    wait_idle("full");
    total++; if (wr_cnt !== 16) begin bad++; $display("FAIL full_wr_cnt got=%0d exp=16", wr_cnt); end
    for (int i = 0; i < wr_cnt && i < 16; i++) begin
      total++;
      if (wr_a[i] !== 32'h100 + 4*i || wr_d[i] !== 32'hA000_0000 + i) begin
        bad++;
        $display("FAIL full_word%0d got=%h/%h exp=%h/%h", i, wr_a[i], wr_d[i], 32'h100 + 4*i, 32'hA000_0000 + i);
      end
    end
    if (wr_cnt == 16) begin
      total++; if (wr_e[0] !== t0 + 3)   begin bad++; $display("FAIL full_first_edge got=%0d exp=%0d", wr_e[0] - t0, 3); end
      total++; if (wr_e[15] !== t0 + 18) begin bad++; $display("FAIL full_last_edge got=%0d exp=%0d", wr_e[15] - t0, 18); end
    end
    total++; if (done_cnt !== 1)       begin bad++; $display("FAIL full_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (done_cyc !== t0 + 18) begin bad++; $display("FAIL full_done_cyc got=%0d exp=18", done_cyc - t0); end
    total++; if (clr_cnt !== 0)        begin bad++; $display("FAIL full_clr_cnt got=%0d exp=0", clr_cnt); end
  endtask

  task automatic test_partial_clear();
    clear_mon();
    do_start(32'h203, 5'd3, 1'b1);
    wait_idle("partial");
    total++; if (wr_cnt !== 3) begin bad++; $display("FAIL part_wr_cnt got=%0d exp=3", wr_cnt); end
    for (int i = 0; i < wr_cnt && i < 3; i++) begin
      total++;
      if (wr_a[i] !== 32'h200 + 4*i) begin bad++; $display("FAIL part_addr%0d got=%h exp=%h", i, wr_a[i], 32'h200 + 4*i); end
    end
    total++; if (clr_cnt !== 1)                 begin bad++; $display("FAIL part_clr_cnt got=%0d exp=1", clr_cnt); end
    total++; if (clr_cyc !== last_we_cyc + 1)   begin bad++; $display("FAIL part_clr_cyc got=%0d exp=%0d", clr_cyc, last_we_cyc + 1); end
    total++; if (clr_cyc !== t0 + 5)            begin bad++; $display("FAIL part_clr_abs got=%0d exp=5", clr_cyc - t0); end
    total++; if (done_cyc !== clr_cyc + 1)      begin bad++; $display("FAIL part_done_cyc got=%0d exp=%0d", done_cyc, clr_cyc + 1); end
    total++; if (overlap_cnt !== 0)             begin bad++; $display("FAIL part_clr_we_overlap got=%0d exp=0", overlap_cnt); end
  endtask

  task automatic test_zero_sat();
    clear_mon();
    do_start(32'h500, 5'd0, 1'b1);
    wait_idle("zero");
    total++; if (wr_cnt !== 0)     begin bad++; $display("FAIL zero_wr_cnt got=%0d exp=0", wr_cnt); end
    total++; if (done_cyc !== t0)  begin bad++; $display("FAIL zero_done_cyc got=%0d exp=0", done_cyc - t0); end
    total++; if (clr_cnt !== 0)    begin bad++; $display("FAIL zero_clr_cnt got=%0d exp=0", clr_cnt); end
    clear_mon();
    do_start(32'h600, 5'd31, 1'b0);
    wait_idle("sat");
    total++; if (wr_cnt !== 16) begin bad++; $display("FAIL sat_wr_cnt got=%0d exp=16", wr_cnt); end
    if (wr_cnt == 16) begin
      total++; if (wr_a[15] !== 32'h63C) begin bad++; $display("FAIL sat_last_addr got=%h exp=0000063c", wr_a[15]); end
    end
  endtask

  task automatic test_abuse_wrap();
    clear_mon();
    do_start(32'hFFFF_FFF8, 5'd3, 1'b0);
    start = 1'b1; base_addr = 32'h0; count = 5'd16; clear_after = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done("abuse");
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abuse_done_start busy=%b exp=0", busy); end
    repeat (3) @(negedge CLK);
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL abuse_idle busy=%b exp=0", busy); end
    total++; if (wr_cnt !== 3)   begin bad++; $display("FAIL abuse_wr_cnt got=%0d exp=3", wr_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL abuse_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (clr_cnt !== 0)  begin bad++; $display("FAIL abuse_clr_cnt got=%0d exp=0", clr_cnt); end
    if (wr_cnt == 3) begin
      total++; if (wr_a[0] !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_a0 got=%h exp=fffffff8", wr_a[0]); end
      total++; if (wr_a[1] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_a1 got=%h exp=fffffffc", wr_a[1]); end
      total++; if (wr_a[2] !== 32'h0000_0000) begin bad++; $display("FAIL wrap_a2 got=%h exp=00000000", wr_a[2]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    do_start(32'h300, 5'd2, 1'b0);
    wait_done("b2b");
    @(negedge CLK);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle busy=%b exp=0", busy); end
    start = 1'b1; base_addr = 32'h340; count = 5'd1; clear_after = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept busy=%b exp=1", busy); end
    wait_idle("b2b");
    total++; if (wr_cnt !== 3) begin bad++; $display("FAIL b2b_wr_cnt got=%0d exp=3", wr_cnt); end
    if (wr_cnt == 3) begin
      total++; if (wr_a[2] !== 32'h340 || wr_d[2] !== 32'hA000_0000)
        begin bad++; $display("FAIL b2b_word got=%h/%h exp=00000340/a0000000", wr_a[2], wr_d[2]); end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_mon();
    do_start(32'h0, 5'd16, 1'b1);
    while (wr_cnt < 5 && k < 50) begin
      @(posedge CLK);
      k++;
    end
    total++; if (wr_cnt !== 5) begin bad++; $display("FAIL rmid_reach got=%0d exp=5", wr_cnt); end
    #2 RES = 1'b1;
    #1;
    total++; if (ram_we !== 1'b0)         begin bad++; $display("FAIL rmid_we got=%b exp=0", ram_we); end
    total++; if (busy !== 1'b0)           begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (cim_output_reg !== 4'h0) begin bad++; $display("FAIL rmid_sel got=%h exp=0", cim_output_reg); end
    @(negedge CLK);
    RES = 1'b0;
    repeat (4) @(negedge CLK);
    total++; if (wr_cnt !== 5)  begin bad++; $display("FAIL rmid_no_more_wr got=%0d exp=5", wr_cnt); end
    total++; if (clr_cnt !== 0) begin bad++; $display("FAIL rmid_clr got=%0d exp=0", clr_cnt); end
    clear_mon();
    do_start(32'h700, 5'd2, 1'b0);
    wait_idle("rmid_restart");
    total++; if (wr_cnt !== 2 || done_cnt !== 1)
      begin bad++; $display("FAIL rmid_restart wr=%0d done=%0d exp=2/1", wr_cnt, done_cnt); end
    if (wr_cnt == 2) begin
      total++; if (wr_a[1] !== 32'h704 || wr_d[1] !== 32'hA000_0001)
        begin bad++; $display("FAIL rmid_restart_word got=%h/%h exp=00000704/a0000001", wr_a[1], wr_d[1]); end
    end
  endtask

  task automatic test_relu();
    logic [31:0] exp_neg;
`ifdef CIM_DRAIN_RELU_EN
    exp_neg = 32'h0;
`else
    exp_neg = 32'hFFFF_FFF0;
`endif
    cim_mode = 1'b1;
    clear_mon();
    do_start(32'h400, 5'd4, 1'b0);
    wait_idle("relu");
    total++; if (wr_cnt !== 4) begin bad++; $display("FAIL relu_wr_cnt got=%0d exp=4", wr_cnt); end
    for (int i = 0; i < wr_cnt && i < 4; i++) begin
      total++;
      if (wr_d[i] !== ((i % 2 == 0) ? exp_neg : 32'h7)) begin
        bad++;
        $display("FAIL relu_word%0d got=%h exp=%h", i, wr_d[i], (i % 2 == 0) ? exp_neg : 32'h7);
      end
    end
    cim_mode = 1'b0;
  endtask

  initial begin
    be_err = 0;
    clear_mon();
    test_reset();
    test_full_drain();
    test_partial_clear();
    test_zero_sat();
    test_abuse_wrap();
    test_back_to_back();
    test_reset_mid();
    test_relu();
    total++; if (be_err !== 0) begin bad++; $display("FAIL byte_enables errors=%0d exp=0", be_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
